csa_seq_add_ctrl: RTL

- Sequencer that performs a WIDTH-bit addition by time-multiplexing one 4-bit carry-skip adder slice, one nibble per cycle, LSB nibble first.
- Accepts operands on a valid/ready input handshake and returns the sum and carry-out on a valid/ready output handshake.
- Counts how many slices took the skip path; the count feeds skip-path coverage and performance statistics.
- Sits between a datapath requester and the shared carry-skip slice.

---
 rtl/csa_pkg.sv | 21 ++
 rtl/csa_seq_add_ctrl_slice4.sv | 35 +++
 rtl/csa_seq_add_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the nibble-serial carry-skip adder.
// Holds the FSM state enum, the slice width and width helper functions.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int SLICE_W = 4;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/csa_seq_add_ctrl_slice4.sv
// 4-bit carry-skip adder slice, purely combinational.
// Ports: a4/b4/ci in; y4 sum, co carry-out, skip when all propagates set.
module csa_slice4
  import csa_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               ci,
  output logic [SLICE_W-1:0] y4,
  output logic               co,
  output logic               skip
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = a4 & b4;
  assign p = a4 ^ b4;

  always_comb begin
    c = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign y4   = p ^ c[SLICE_W-1:0];
  assign skip = &p;
  // With every bit propagating, the ripple carry equals ci anyway;
  // the bypass just shortens the path.
  assign co   = skip ? ci : c[SLICE_W];

endmodule

// File: rtl/csa_seq_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per cycle through a shared slice.
// Ports: in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout/skip_cnt out.
module csa_seq_add_ctrl
  import csa_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NSLICE = WIDTH / SLICE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          sum,
  output logic                      cout,
  output logic [cnt_w(NSLICE)-1:0]  skip_cnt,
  output logic                      busy
);

  localparam int CW = cnt_w(NSLICE);
  localparam int IW = $clog2(NSLICE);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [CW-1:0]      skip_q, skip_d;

  logic [IW+1:0]      lo;
  logic [SLICE_W-1:0] s_a;
  logic [SLICE_W-1:0] s_b;
  logic [SLICE_W-1:0] s_y;
  logic               s_co;
  logic               s_skip;

  assign lo  = {idx_q, 2'b00};
  assign s_a = a_q[lo +: SLICE_W];
  assign s_b = b_q[lo +: SLICE_W];

  csa_slice4 u_slice (
    .a4   (s_a),
    .b4   (s_b),
    .ci   (carry_q),
    .y4   (s_y),
    .co   (s_co),
    .skip (s_skip)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    skip_d  = skip_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          skip_d  = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[lo +: SLICE_W] = s_y;
        carry_d = s_co;
        if (s_skip) begin
          skip_d = skip_q + CW'(1);
        end
        if (idx_q == LAST) begin
          cout_d  = s_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      skip_q  <= skip_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign skip_cnt  = skip_q;

endmodule
